ask2_keyboard_scanner: RTL and testbench

- Scans a 4x8 key matrix, synchronizes and debounces it, and produces a 6-bit key word that drives the 6-bit in_port of the CPU's keyboard PIO.
- Key word layout is {pressed, code[4:0]}. Software polls the PIO and sees a stable, debounced value.
- key_strobe pulses for one cycle on every committed change; it is reserved for a future edge-capture/IRQ PIO.

---
 rtl/ask2_kbd_pkg.sv | 30 +++
 rtl/ask2_keyboard_scanner_if.sv | 36 +++
 rtl/ask2_kbd_row_scanner.sv | 109 ++++++++++
 rtl/ask2_keyboard_scanner.sv | 145 ++++++++++++++
 tb/tb_ask2_keyboard_scanner.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/ask2_kbd_pkg.sv
// ============================================================================
// Module   : ask2_kbd_pkg
// Brief    : Shared widths, key-word layout and debounce states for the scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ask2_kbd_pkg;

    localparam int KEY_CODE_W  = 5;
    localparam int KEY_WORD_W  = 6;
    localparam int PRESSED_BIT = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kbd_state_t;

    // Linear key code: row-major, so lower rows always outrank higher ones.
    function automatic logic [KEY_CODE_W-1:0] make_code(input int row, input int col, input int cols);
        int code;
        code = row * cols + col;
        return code[KEY_CODE_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ask2_keyboard_scanner_if.sv
// ============================================================================
// Module   : ask2_keyboard_scanner_if
// Brief    : Matrix pins and PIO key word of the keyboard scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ask2_keyboard_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 8
);
    import ask2_kbd_pkg::*;

    logic [ROWS-1:0]       row_drive;
    logic [COLS-1:0]       col_sense;
    logic [KEY_WORD_W-1:0] key_out;
    logic                  key_strobe;

    // master: the scanner; slave: the matrix and the PIO it feeds.
    modport master (
        output row_drive,
        output key_out,
        output key_strobe,
        input  col_sense
    );

    modport slave (
        input  row_drive,
        input  key_out,
        input  key_strobe,
        output col_sense
    );

endinterface

`default_nettype wire

// File: rtl/ask2_kbd_row_scanner.sv
// ============================================================================
// Module   : ask2_kbd_row_scanner
// Brief    : Column synchronizer, row prescaler/ring and per-frame key reducer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ask2_kbd_row_scanner
    import ask2_kbd_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 8,
    parameter int SCAN_DIV = 1000
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [COLS-1:0]       i_col_sense,
    output logic      [ROWS-1:0]       o_row_drive,
    output logic                       o_frame_done,
    output logic                       o_frame_hit,
    output logic      [KEY_CODE_W-1:0] o_frame_code
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(ROWS - 1);

    logic [COLS-1:0]       r_col_meta;
    logic [COLS-1:0]       r_col_sync;
    logic [DIV_W-1:0]      r_div;
    logic [ROW_W-1:0]      r_row;
    logic [ROWS-1:0]       r_row_drive;
    logic                  r_acc_hit;
    logic [KEY_CODE_W-1:0] r_acc_code;
    logic                  r_frame_done;
    logic                  r_frame_hit;
    logic [KEY_CODE_W-1:0] r_frame_code;

    logic                  w_row_hit;
    logic [COL_W-1:0]      w_col_idx;
    logic [KEY_CODE_W-1:0] w_row_code;
    logic [ROW_W-1:0]      w_next_row;
    logic                  w_acc_hit_n;
    logic [KEY_CODE_W-1:0] w_acc_code_n;

    // Lowest active (low) column in the currently driven row.
    always_comb begin
        w_row_hit = 1'b0;
        w_col_idx = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!r_col_sync[c]) begin
                w_row_hit = 1'b1;
                w_col_idx = COL_W'(c);
            end
        end
    end

    assign w_row_code   = w_row_hit ? make_code(int'(r_row), int'(w_col_idx), COLS) : '0;
    assign w_next_row   = (r_row == c_row_last) ? '0 : r_row + 1'b1;
    assign w_acc_hit_n  = r_acc_hit | w_row_hit;
    assign w_acc_code_n = r_acc_hit ? r_acc_code : w_row_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_meta   <= '0;
            r_col_sync   <= '0;
            r_div        <= '0;
            r_row        <= '0;
            r_row_drive  <= ~ROWS'(1);
            r_acc_hit    <= 1'b0;
            r_acc_code   <= '0;
            r_frame_done <= 1'b0;
            r_frame_hit  <= 1'b0;
            r_frame_code <= '0;
        end else begin
            r_col_meta   <= i_col_sense;
            r_col_sync   <= r_col_meta;
            r_frame_done <= 1'b0;
            if (r_div == c_div_last) begin
                r_div       <= '0;
                r_row       <= w_next_row;
                r_row_drive <= ~(ROWS'(1) << w_next_row);
                if (r_row == c_row_last) begin
                    r_frame_done <= 1'b1;
                    r_frame_hit  <= w_acc_hit_n;
                    r_frame_code <= w_acc_code_n;
                    r_acc_hit    <= 1'b0;
                    r_acc_code   <= '0;
                end else begin
                    r_acc_hit    <= w_acc_hit_n;
                    r_acc_code   <= w_acc_code_n;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_row_drive  = r_row_drive;
    assign o_frame_done = r_frame_done;
    assign o_frame_hit  = r_frame_hit;
    assign o_frame_code = r_frame_code;

endmodule

`default_nettype wire

// File: rtl/ask2_keyboard_scanner.sv
// ============================================================================
// Module   : ask2_keyboard_scanner
// Brief    : 4x8 matrix scanner with frame debounce producing {pressed, code}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ask2_keyboard_scanner
    import ask2_kbd_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 8,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    ask2_keyboard_scanner_if.master kbd
);

    localparam int             CNT_W     = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] c_cnt_db  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam bit             c_db_one  = (DEBOUNCE_SCANS == 1);

    logic                  w_frame_done;
    logic                  w_frame_hit;
    logic [KEY_CODE_W-1:0] w_frame_code;
    logic [ROWS-1:0]       w_row_drive;
    logic                  w_match_cand;
    logic                  w_match_held;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_cnt_done;

    kbd_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [KEY_CODE_W-1:0] r_cand;
    logic [KEY_WORD_W-1:0] r_key_out;
    logic                  r_key_strobe;

    ask2_kbd_row_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_row_scanner (
        .clk          (clk),
        .reset        (reset),
        .i_col_sense  (kbd.col_sense),
        .o_row_drive  (w_row_drive),
        .o_frame_done (w_frame_done),
        .o_frame_hit  (w_frame_hit),
        .o_frame_code (w_frame_code)
    );

    assign w_match_cand = w_frame_hit && (w_frame_code == r_cand);
    assign w_match_held = w_frame_hit && (w_frame_code == r_key_out[KEY_CODE_W-1:0]);
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_cnt_done   = (w_cnt_inc == c_cnt_db);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cand       <= '0;
            r_key_out    <= '0;
            r_key_strobe <= 1'b0;
        end else begin
            r_key_strobe <= 1'b0;
            if (w_frame_done) begin
                case (r_state)
                    IDLE: begin
                        if (w_frame_hit) begin
                            r_cand <= w_frame_code;
                            if (c_db_one) begin
                                r_key_out    <= {1'b1, w_frame_code};
                                r_key_strobe <= 1'b1;
                                r_cnt        <= '0;
                                r_state      <= HELD;
                            end else begin
                                r_cnt   <= c_cnt_one;
                                r_state <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (w_match_cand) begin
                            if (w_cnt_done) begin
                                r_key_out    <= {1'b1, r_cand};
                                r_key_strobe <= 1'b1;
                                r_cnt        <= '0;
                                r_state      <= HELD;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else if (w_frame_hit) begin
                            r_cand <= w_frame_code;
                            r_cnt  <= c_cnt_one;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (!w_match_held) begin
                            if (c_db_one) begin
                                r_key_out[PRESSED_BIT] <= 1'b0;
                                r_key_strobe           <= 1'b1;
                                r_cnt                  <= '0;
                                r_state                <= IDLE;
                            end else begin
                                r_cnt   <= c_cnt_one;
                                r_state <= RELEASE_DB;
                            end
                        end
                    end
                    RELEASE_DB: begin
                        if (w_match_held) begin
                            r_cnt   <= '0;
                            r_state <= HELD;
                        end else if (w_cnt_done) begin
                            // Code field is kept so software can see which key went up.
                            r_key_out[PRESSED_BIT] <= 1'b0;
                            r_key_strobe           <= 1'b1;
                            r_cnt                  <= '0;
                            r_state                <= IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign kbd.row_drive  = w_row_drive;
    assign kbd.key_out    = r_key_out;
    assign kbd.key_strobe = r_key_strobe;

endmodule

`default_nettype wire

// File: tb/tb_ask2_keyboard_scanner.sv
// ============================================================================
// Module   : tb_ask2_keyboard_scanner
// Brief    : Scoreboard bench: directed key patterns on a modelled 4x8 matrix.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ask2_keyboard_scanner;
    import ask2_kbd_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 8;

    typedef struct {
        logic [KEY_WORD_W-1:0] key;
        int                    at;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] keys  = '0;
    logic [COLS-1:0] w_cols;
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb_q[$];
    logic [KEY_WORD_W-1:0] prev_key = '0;

    ask2_keyboard_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kbd_if ();

    ask2_keyboard_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kbd   (kbd_if)
    );

    always #5 clk = ~clk;

    // Pressed key shorts its column low while its row is driven low.
    always_comb begin
        w_cols = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys[r*COLS+c] && !kbd_if.row_drive[r]) w_cols[c] = 1'b0;
    end
    assign kbd_if.col_sense = w_cols;

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // Monitor: every strobe must match the oldest expectation, and key_out may only move with a strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_key = kbd_if.key_out;
            end else begin
                n_cmp++;
                if (kbd_if.key_strobe) begin
                    if (sb_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_strobe: got key_out=%b at cycle %0d, no strobe required",
                                 kbd_if.key_out, cyc);
                    end else begin
                        e = sb_q.pop_front();
                        if (kbd_if.key_out !== e.key || cyc != e.at) begin
                            n_bad++;
                            $display("FAIL strobe_commit: got key_out=%b at cycle %0d, required %b at cycle %0d",
                                     kbd_if.key_out, cyc, e.key, e.at);
                        end
                    end
                end else if (kbd_if.key_out !== prev_key) begin
                    n_bad++;
                    $display("FAIL key_out_stable: got %b without strobe at cycle %0d, required %b",
                             kbd_if.key_out, cyc, prev_key);
                end
                prev_key = kbd_if.key_out;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d required strobes not seen, required 0 outstanding (cycle %0d)",
                     name, sb_q.size(), cyc);
            sb_q.delete();
        end
    endtask

    task automatic expect_key(input logic [KEY_WORD_W-1:0] key, input int at);
        exp_t e;
        e.key = key;
        e.at  = at;
        sb_q.push_back(e);
    endtask

    // Three reset edges; afterwards the bench sits in cycle 0 with row 0 driven.
    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_key_out", 32'(kbd_if.key_out), 32'h0);
        check("rst_key_strobe", 32'(kbd_if.key_strobe), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_row_drive", 32'(kbd_if.row_drive), 32'b1110);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset with every key down, then an idle matrix.
        keys = '1;
        do_reset();
        keys = '0;
        wait_cyc(4);
        check("row_advance", 32'(kbd_if.row_drive), 32'b1101);
        wait_cyc(64);
        check_drained("idle_no_strobe");

        // Clean press of code 10 (row 1, col 2), long hold, then release.
        do_reset();
        keys = 32'(1) << 10;
        expect_key(6'b101010, 49);
        wait_cyc(60);
        check_drained("clean_press");
        check("held_key_out", 32'(kbd_if.key_out), 32'b101010);
        wait_cyc(128);
        keys = '0;
        expect_key(6'b001010, 177);
        wait_cyc(220);
        check_drained("release");

        // Bounce: 2 frames down, 1 up, 3 down.
        do_reset();
        keys = 32'(1) << 10;
        wait_cyc(32);
        keys = '0;
        wait_cyc(48);
        keys = 32'(1) << 10;
        expect_key(6'b101010, 97);
        wait_cyc(140);
        check_drained("bounce");

        // Codes 3 and 17 together, then 3 released while 17 stays down.
        do_reset();
        keys = (32'(1) << 3) | (32'(1) << 17);
        expect_key(6'b100011, 49);
        wait_cyc(80);
        keys = 32'(1) << 17;
        expect_key(6'b000011, 129);
        expect_key(6'b110001, 177);
        wait_cyc(220);
        check_drained("multi_key");

        // Reset in the middle of press debounce; key stays held throughout.
        do_reset();
        keys = 32'(1) << 10;
        wait_cyc(40);
        check_drained("pre_reset_no_commit");
        check("mid_press_key_out", 32'(kbd_if.key_out), 32'h0);
        do_reset();
        expect_key(6'b101010, 49);
        wait_cyc(70);
        check_drained("press_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
